// File: rtl/flt_seq_pkg.sv
// Shared types and defaults for the float-converter memory sequencer.
// State encoding plus default operand/result addresses and data width.
package flt_seq_pkg;

   localparam int unsigned DATA_W = 16;

   localparam logic [7:0] SRC_ADDR_DEF = 8'd64;
   localparam logic [7:0] DST_ADDR_DEF = 8'd66;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_HI,
      ST_RD_LO,
      ST_LD_WAIT,
      ST_OFFER,
      ST_WAIT_RES,
      ST_WR_HI,
      ST_WR_LO,
      ST_DONE
   } state_t;

endpackage

// File: rtl/flt_mem_seq.sv
// Fetches a half-precision operand from byte memory, hands it to the
// converter, writes the integer result back; watchdog aborts stalls.
module flt_mem_seq
   import flt_seq_pkg::*;
#(
   parameter logic [7:0] SRC_ADDR    = SRC_ADDR_DEF,
   parameter logic [7:0] DST_ADDR    = DST_ADDR_DEF,
   parameter int         TIMEOUT_CYC = 64
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   output logic [7:0]        mem_addr_o,
   output logic              mem_rd_o,
   output logic              mem_wr_o,
   output logic [7:0]        mem_wdata_o,
   input  logic [7:0]        mem_rdata_i,
   output logic              op_valid_o,
   input  logic              op_ready_i,
   output logic [DATA_W-1:0] op_o,
   input  logic              res_valid_i,
   output logic              res_ready_o,
   input  logic [DATA_W-1:0] res_i,
   output logic              done_o,
   output logic              err_o
);

   localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] op_q, op_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [7:0]        wd_q, wd_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         res_q   <= '0;
         wd_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         res_q   <= res_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      res_d       = res_q;
      wd_d        = wd_q;
      done_d      = done_q;
      err_d       = err_q;
      mem_addr_o  = '0;
      mem_rd_o    = 1'b0;
      mem_wr_o    = 1'b0;
      mem_wdata_o = '0;
      op_valid_o  = 1'b0;
      res_ready_o = 1'b0;
      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d = ST_RD_HI;
               done_d  = 1'b0;
               err_d   = 1'b0;
               wd_d    = '0;
            end
         end
         ST_RD_HI: begin
            mem_addr_o = SRC_ADDR;
            mem_rd_o   = 1'b1;
            state_d    = ST_RD_LO;
         end
         ST_RD_LO: begin
            mem_addr_o = SRC_ADDR + 8'd1;
            mem_rd_o   = 1'b1;
            op_d[15:8] = mem_rdata_i;
            state_d    = ST_LD_WAIT;
         end
         ST_LD_WAIT: begin
            op_d[7:0] = mem_rdata_i;
            wd_d      = '0;
            state_d   = ST_OFFER;
         end
         // A handshake on the watchdog's last cycle takes priority.
         ST_OFFER: begin
            op_valid_o = 1'b1;
            wd_d       = wd_q + 8'd1;
            if (op_ready_i) begin
               state_d = ST_WAIT_RES;
            end else if (wd_q == WD_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         ST_WAIT_RES: begin
            res_ready_o = 1'b1;
            wd_d        = wd_q + 8'd1;
            if (res_valid_i) begin
               res_d   = res_i;
               state_d = ST_WR_HI;
            end else if (wd_q == WD_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end
         ST_WR_HI: begin
            mem_addr_o  = DST_ADDR;
            mem_wr_o    = 1'b1;
            mem_wdata_o = res_q[15:8];
            state_d     = ST_WR_LO;
         end
         ST_WR_LO: begin
            mem_addr_o  = DST_ADDR + 8'd1;
            mem_wr_o    = 1'b1;
            mem_wdata_o = res_q[7:0];
            state_d     = ST_DONE;
            done_d      = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign op_o   = op_q;
   assign done_o = done_q;
   assign err_o  = err_q;

endmodule

// File: tb/tb_flt_mem_seq.sv
// Directed bench: instance 0 uses the default watchdog,
// instance 1 a short one (8 cycles) for abort and boundary cases.
module tb_flt_mem_seq;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        start_v   [2];
   logic [7:0]  addr_v    [2];
   logic        rd_v      [2];
   logic        wr_v      [2];
   logic [7:0]  wdata_v   [2];
   logic [7:0]  rdata_v   [2];
   logic        opv_v     [2];
   logic        opr_v     [2];
   logic [15:0] op_v      [2];
   logic        resv_v    [2];
   logic        resr_v    [2];
   logic [15:0] res_val   [2];
   logic        done_v    [2];
   logic        err_v     [2];
   int          rdy_dly   [2];
   int          rsp_dly   [2];
   logic        pl_we     [2];
   logic [7:0]  pl_addr;
   logic [7:0]  pl_data;

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [7:0]  mem [256];
      int          op_cnt  = 0;
      int          res_cnt = 0;
      int          wr_cnt  = 0;
      int          unst    = 0;
      int          both    = 0;
      logic        opv_prev = 1'b0;
      logic [15:0] op_prev  = '0;

      flt_mem_seq #(
         .SRC_ADDR    (8'd64),
         .DST_ADDR    (8'd66),
         .TIMEOUT_CYC ((g == 0) ? 64 : 8)
      ) u_dut (
         .clk_i       (clk),
         .reset_i     (reset_i),
         .start_i     (start_v[g]),
         .mem_addr_o  (addr_v[g]),
         .mem_rd_o    (rd_v[g]),
         .mem_wr_o    (wr_v[g]),
         .mem_wdata_o (wdata_v[g]),
         .mem_rdata_i (rdata_v[g]),
         .op_valid_o  (opv_v[g]),
         .op_ready_i  (opr_v[g]),
         .op_o        (op_v[g]),
         .res_valid_i (resv_v[g]),
         .res_ready_o (resr_v[g]),
         .res_i       (res_val[g]),
         .done_o      (done_v[g]),
         .err_o       (err_v[g])
      );

      assign opr_v[g]  = opv_v[g] && (op_cnt >= rdy_dly[g]);
      assign resv_v[g] = resr_v[g] && (res_cnt >= rsp_dly[g]);

      always @(posedge clk) begin
         if (pl_we[g])
            mem[pl_addr] <= pl_data;
         else if (wr_v[g])
            mem[addr_v[g]] <= wdata_v[g];
         if (rd_v[g])
            rdata_v[g] <= mem[addr_v[g]];
         op_cnt  <= opv_v[g] ? op_cnt + 1 : 0;
         res_cnt <= resr_v[g] ? res_cnt + 1 : 0;
         if (wr_v[g])
            wr_cnt <= wr_cnt + 1;
         if (opv_v[g] && opv_prev && op_v[g] !== op_prev)
            unst <= unst + 1;
         if (opv_v[g] && resr_v[g])
            both <= both + 1;
         opv_prev <= opv_v[g];
         op_prev  <= op_v[g];
      end
   end

   function automatic logic [7:0] mem_at(input int g, input logic [7:0] a);
      return (g == 1) ? g_dut[1].mem[a] : g_dut[0].mem[a];
   endfunction

   function automatic int wrs(input int g);
      return (g == 1) ? g_dut[1].wr_cnt : g_dut[0].wr_cnt;
   endfunction

   function automatic int unst_of(input int g);
      return (g == 1) ? g_dut[1].unst : g_dut[0].unst;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_rst(input int g);
      chk("rst_addr", 32'(addr_v[g]), 0);
      chk("rst_rd", 32'(rd_v[g]), 0);
      chk("rst_wr", 32'(wr_v[g]), 0);
      chk("rst_wdata", 32'(wdata_v[g]), 0);
      chk("rst_opv", 32'(opv_v[g]), 0);
      chk("rst_op", 32'(op_v[g]), 0);
      chk("rst_resr", 32'(resr_v[g]), 0);
      chk("rst_done", 32'(done_v[g]), 0);
      chk("rst_err", 32'(err_v[g]), 0);
   endtask

   task automatic poke(input int g, input logic [7:0] a,
                       input logic [7:0] d);
      pl_we[g] = 1'b1;
      pl_addr  = a;
      pl_data  = d;
      tick();
      pl_we[g] = 1'b0;
   endtask

   task automatic run(input int g, input int rdy, input int rsp,
                      input bit poke_start, output int cyc);
      bit poked = 1'b0;
      rdy_dly[g] = rdy;
      rsp_dly[g] = rsp;
      start_v[g] = 1'b1;
      tick();
      start_v[g] = 1'b0;
      cyc = 1;
      chk("rd_hi_done", 32'(done_v[g]), 0);
      chk("rd_hi_rd", 32'(rd_v[g]), 1);
      chk("rd_hi_addr", 32'(addr_v[g]), 64);
      while (!done_v[g] && cyc < 200) begin
         if (poke_start && !poked && resr_v[g]) begin
            start_v[g] = 1'b1;
            poked = 1'b1;
         end
         tick();
         start_v[g] = 1'b0;
         cyc++;
      end
      chk("run_bound", 32'(cyc < 200), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int cyc;
      int w0;
      int u0;
      int n;
      reset_i = 1'b1;
      pl_addr = '0;
      pl_data = '0;
      for (int i = 0; i < 2; i++) begin
         start_v[i] = 1'b0;
         pl_we[i]   = 1'b0;
         rdy_dly[i] = 0;
         rsp_dly[i] = 0;
         res_val[i] = '0;
      end
      tick();
      tick();
      chk_rst(0);
      chk_rst(1);
      reset_i = 1'b0;
      tick();

      // Best case: operand 3C00, result 0001
      poke(0, 8'd64, 8'h3C);
      poke(0, 8'd65, 8'h00);
      poke(0, 8'd66, 8'hAA);
      poke(0, 8'd67, 8'hAA);
      res_val[0] = 16'h0001;
      w0 = wrs(0);
      run(0, 0, 0, 1'b0, cyc);
      chk("t1_cycles", 32'(cyc), 8);
      chk("t1_op", 32'(op_v[0]), 32'h3C00);
      chk("t1_mem66", 32'(mem_at(0, 8'd66)), 32'h00);
      chk("t1_mem67", 32'(mem_at(0, 8'd67)), 32'h01);
      chk("t1_err", 32'(err_v[0]), 0);
      chk("t1_writes", 32'(wrs(0) - w0), 2);

      // Stalls: ready low 3, result valid low 5
      res_val[0] = 16'h1234;
      w0 = wrs(0);
      u0 = unst_of(0);
      run(0, 3, 5, 1'b0, cyc);
      chk("t2_cycles", 32'(cyc), 16);
      chk("t2_stable", 32'(unst_of(0) - u0), 0);
      chk("t2_writes", 32'(wrs(0) - w0), 2);
      chk("t2_mem66", 32'(mem_at(0, 8'd66)), 32'h12);
      chk("t2_mem67", 32'(mem_at(0, 8'd67)), 32'h34);
      chk("t2_err", 32'(err_v[0]), 0);

      // Restart after DONE; stray start in WAIT_RES
      poke(0, 8'd64, 8'hC5);
      poke(0, 8'd65, 8'h00);
      res_val[0] = 16'h8005;
      run(0, 0, 2, 1'b1, cyc);
      chk("t5_cycles", 32'(cyc), 10);
      chk("t5_op", 32'(op_v[0]), 32'hC500);
      chk("t5_mem66", 32'(mem_at(0, 8'd66)), 32'h80);
      chk("t5_mem67", 32'(mem_at(0, 8'd67)), 32'h05);

      // Short watchdog: result on the last allowed cycle wins
      poke(1, 8'd64, 8'h3C);
      poke(1, 8'd65, 8'h00);
      poke(1, 8'd66, 8'hAA);
      poke(1, 8'd67, 8'hAA);
      res_val[1] = 16'h00FF;
      run(1, 0, 6, 1'b0, cyc);
      chk("wd_edge_cycles", 32'(cyc), 14);
      chk("wd_edge_err", 32'(err_v[1]), 0);
      chk("wd_edge_mem67", 32'(mem_at(1, 8'd67)), 32'hFF);

      // Result never arrives
      poke(1, 8'd66, 8'h11);
      poke(1, 8'd67, 8'h22);
      w0 = wrs(1);
      run(1, 0, 255, 1'b0, cyc);
      chk("wd_res_cycles", 32'(cyc), 12);
      chk("wd_res_err", 32'(err_v[1]), 1);
      chk("wd_res_writes", 32'(wrs(1) - w0), 0);
      chk("wd_res_mem66", 32'(mem_at(1, 8'd66)), 32'h11);
      chk("wd_res_mem67", 32'(mem_at(1, 8'd67)), 32'h22);

      // Operand never accepted
      run(1, 255, 0, 1'b0, cyc);
      chk("wd_op_cycles", 32'(cyc), 12);
      chk("wd_op_err", 32'(err_v[1]), 1);

      // Normal run after abort clears err
      run(1, 1, 0, 1'b0, cyc);
      chk("wd_after_cycles", 32'(cyc), 9);
      chk("wd_after_err", 32'(err_v[1]), 0);

      // Reset while in WR_HI
      poke(0, 8'd66, 8'hA5);
      poke(0, 8'd67, 8'hA5);
      res_val[0] = 16'hBEEF;
      rdy_dly[0] = 0;
      rsp_dly[0] = 0;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      n = 0;
      while (!wr_v[0] && n < 20) begin
         tick();
         n++;
      end
      chk("wr_hi_reach", 32'(wr_v[0]), 1);
      chk("wr_hi_addr", 32'(addr_v[0]), 66);
      reset_i = 1'b1;
      tick();
      chk_rst(0);
      reset_i = 1'b0;
      tick();
      chk("rst_mem67", 32'(mem_at(0, 8'd67)), 32'hA5);
      chk("rst_idle_wr", 32'(wr_v[0]), 0);

      chk("excl_0", 32'(g_dut[0].both), 0);
      chk("excl_1", 32'(g_dut[1].both), 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
